// File: rtl/cordic_pkg.sv
// Shared definitions for the cordic front end and the downstream quadrant fixer.
// Holds the angle format (signed Q1.30 in 32 bits), the pi/2 scale constant,
// the quadrant tag type and the default cordic core latency.
package cordic_pkg;

  // Angle words are signed Q1.30: 1 sign bit, 1 integer bit, 30 fraction bits.
  localparam int ANGLE_W    = 32;
  localparam int ANGLE_FRAC = 30;

  // pi/2 in signed Q1.30.
  localparam logic [31:0] PI_2 = 32'h6487ED51;

  // Clock cycles from the cordic angle input to its sin/cos output.
  localparam int CORDIC_LAT_DEFAULT = 32;

  // Quadrant of the full-turn phase; selects the sign/swap applied to the
  // first-quadrant sin/cos produced by the core.
  typedef enum logic [1:0] {
    QUAD_0   = 2'd0,  // sin = s,  cos = c
    QUAD_90  = 2'd1,  // sin = c,  cos = -s
    QUAD_180 = 2'd2,  // sin = -s, cos = -c
    QUAD_270 = 2'd3   // sin = -c, cos = s
  } quad_t;

endpackage

// File: rtl/cordic_tag_delay.sv
// Fixed-depth shift register for a {valid, data} tag that must stay aligned
// with a free-running pipeline. Advances every clock; a synchronous clear
// drops every valid bit in flight while leaving the data bits untouched.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears valid and data)
//   clr       synchronous clear of all valid bits
//   in_valid  valid bit entering the line
//   in_data   WIDTH-bit tag entering the line
//   out_valid in_valid delayed by DEPTH cycles
//   out_data  in_data delayed by DEPTH cycles
module cordic_tag_delay #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_sr;
  logic [WIDTH-1:0] data_sr [DEPTH];

  // Valid and data shift together each cycle. The valid chain is written
  // element by element so a depth of one needs no special case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_sr[i] <= '0;
      end
    end else begin
      valid_sr[0] <= in_valid & ~clr;
      data_sr[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1] & ~clr;
        data_sr[i]  <= data_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_data  = data_sr[DEPTH-1];

endmodule

// File: rtl/cordic_phase_front.sv
// Phase front end for the cordic sin/cos core. A 32-bit NCO accumulator
// (full scale = one turn) is offset, split into a 2-bit quadrant and a 30-bit
// residue, and the residue is scaled to a first-quadrant angle in Q1.30.
// The quadrant tag is delayed by the core latency so it meets the core output.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           emit one sample this cycle and advance the phase
//   clr          synchronous clear of phase and all valid flags (beats en)
//   freq         phase increment per enabled cycle
//   phase_off    offset added to the phase before splitting
//   angle        Q1.30 angle to the cordic core, 0..PI_2
//   angle_valid  angle holds a new sample
//   quad         quadrant tag aligned with the cordic output
//   quad_valid   angle_valid delayed by CORDIC_LAT cycles
module cordic_phase_front #(
  parameter int          CORDIC_LAT = cordic_pkg::CORDIC_LAT_DEFAULT,
  parameter logic [31:0] PI_2       = cordic_pkg::PI_2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] freq,
  input  logic [31:0] phase_off,
  output logic [31:0] angle,
  output logic        angle_valid,
  output logic [1:0]  quad,
  output logic        quad_valid
);

  import cordic_pkg::*;

  // Adding half an output LSB before the shift gives round-half-up.
  localparam logic [61:0] ROUND_HALF = 62'd1 << (ANGLE_FRAC - 1);

  logic [31:0] phase;
  logic [31:0] p1;
  logic        v1;
  quad_t       q2;
  logic [61:0] prod;
  logic        v2;
  quad_t       quad3;
  logic [31:0] angle_next;
  logic        take;

  assign take = en & ~clr;

  // Accumulator: the sample taken this cycle sees the pre-increment phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + freq;
    end
  end

  // Stage 1: apply the offset. Data only moves when a sample is taken so
  // later stages can hold their last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= take;
      if (take) begin
        p1 <= phase + phase_off;
      end
    end
  end

  // Stage 2: split off the quadrant and scale the residue by pi/2. The
  // residue is a fraction of a quarter turn in units of 2^-30.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q2   <= QUAD_0;
      prod <= '0;
      v2   <= 1'b0;
    end else begin
      v2 <= v1 & ~clr;
      if (v1) begin
        q2   <= quad_t'(p1[31:30]);
        prod <= 62'(p1[29:0]) * 62'(PI_2);
      end
    end
  end

  // The product is below 2^61, so the rounded, shifted result always fits
  // in 31 bits and the Q1.30 sign bit stays clear.
  assign angle_next = 32'((prod + ROUND_HALF) >> ANGLE_FRAC);

  // Stage 3: output register for the cordic angle input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle       <= '0;
      quad3       <= QUAD_0;
      angle_valid <= 1'b0;
    end else begin
      angle_valid <= v2 & ~clr;
      if (v2) begin
        angle <= angle_next;
        quad3 <= q2;
      end
    end
  end

  // Quadrant tag rides alongside the free-running core pipeline.
  cordic_tag_delay #(
    .WIDTH (2),
    .DEPTH (CORDIC_LAT)
  ) u_tag_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (angle_valid),
    .in_data   (quad3),
    .out_valid (quad_valid),
    .out_data  (quad)
  );

endmodule

// File: tb/tb_cordic_phase_front.sv
// Directed testbench for cordic_phase_front: a table of single-sample phase
// offsets with hand-computed angles and quadrants, plus hand-written
// sequences for quadrant stepping, phase wrap, clr/en collision and reset
// asserted mid-stream.
module tb_cordic_phase_front;

  localparam int LAT = 32;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [31:0] freq;
  logic [31:0] phase_off;
  logic [31:0] angle;
  logic        angle_valid;
  logic [1:0]  quad;
  logic        quad_valid;

  int vec_count;
  int miss_count;

  typedef struct {
    logic [31:0] off;
    logic [31:0] exp_angle;
    logic [1:0]  exp_quad;
  } vec_t;

  vec_t vecs[9];

  logic [31:0] exp_angle_q[4];
  logic [1:0]  exp_quad_q[4];

  cordic_phase_front #(
    .CORDIC_LAT (LAT),
    .PI_2       (32'h6487ED51)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .clr         (clr),
    .freq        (freq),
    .phase_off   (phase_off),
    .angle       (angle),
    .angle_valid (angle_valid),
    .quad        (quad),
    .quad_valid  (quad_valid)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive inputs just after an edge, then let the next edge sample them;
  // outputs are read 1 ns after that edge.
  task automatic applyStimulus(input logic e, input logic c,
                               input logic [31:0] f, input logic [31:0] o);
    en        = e;
    clr       = c;
    freq      = f;
    phase_off = o;
    @(posedge clk);
    #1;
  endtask

  // One sample from a cleared phase: angle_valid on the third edge,
  // quad_valid LAT edges later.
  task automatic runSingle(input vec_t v, input int idx);
    applyStimulus(1'b0, 1'b1, 32'h0, v.off);
    applyStimulus(1'b1, 1'b0, 32'h0, v.off);
    checkOutput($sformatf("v%0d av e1", idx), 32'(angle_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, v.off);
    checkOutput($sformatf("v%0d av e2", idx), 32'(angle_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, v.off);
    checkOutput($sformatf("v%0d av e3", idx), 32'(angle_valid), 32'd1);
    checkOutput($sformatf("v%0d angle", idx), angle, v.exp_angle);
    applyStimulus(1'b0, 1'b0, 32'h0, v.off);
    checkOutput($sformatf("v%0d av e4", idx), 32'(angle_valid), 32'd0);
    checkOutput($sformatf("v%0d angle hold", idx), angle, v.exp_angle);
    for (int k = 5; k <= 3 + LAT; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, v.off);
      if (k == 2 + LAT) begin
        checkOutput($sformatf("v%0d qv early", idx), 32'(quad_valid), 32'd0);
      end
      if (k == 3 + LAT) begin
        checkOutput($sformatf("v%0d qv", idx), 32'(quad_valid), 32'd1);
        checkOutput($sformatf("v%0d quad", idx), 32'(quad), 32'(v.exp_quad));
      end
    end
  endtask

  // en held for n cycles from a cleared phase; expectations come from
  // exp_angle_q / exp_quad_q, indexed by sample number.
  task automatic runStream(input int n, input logic [31:0] f,
                           input logic [31:0] o, input string tag);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 1; k <= 8 + LAT; k++) begin
      applyStimulus(k <= n, 1'b0, f, o);
      if (k >= 3 && k <= n + 2) begin
        checkOutput($sformatf("%s av k%0d", tag, k), 32'(angle_valid), 32'd1);
        checkOutput($sformatf("%s angle k%0d", tag, k), angle, exp_angle_q[k-3]);
      end else begin
        checkOutput($sformatf("%s av k%0d", tag, k), 32'(angle_valid), 32'd0);
      end
      if (k >= 3 + LAT && k <= n + 2 + LAT) begin
        checkOutput($sformatf("%s qv k%0d", tag, k), 32'(quad_valid), 32'd1);
        checkOutput($sformatf("%s quad k%0d", tag, k), 32'(quad),
                    32'(exp_quad_q[k-3-LAT]));
      end else begin
        checkOutput($sformatf("%s qv k%0d", tag, k), 32'(quad_valid), 32'd0);
      end
    end
  endtask

  // Main sequence.
  initial begin
    int first_qv;
    int first_av;
    int qv_pulses;
    logic [31:0] av_angle;
    logic exp_av;
    logic exp_qv;

    vec_count  = 0;
    miss_count = 0;

    // Offsets from a zero phase. Angle = ((residue * PI_2) + 2^29) >> 30.
    vecs[0] = '{32'h20000000, 32'h3243F6A9, 2'd0};  // pi/4
    vecs[1] = '{32'h7FFFFFFF, 32'h6487ED4F, 2'd1};  // max residue: PI_2 - 2
    vecs[2] = '{32'h00000000, 32'h00000000, 2'd0};
    vecs[3] = '{32'hC0000000, 32'h00000000, 2'd3};
    vecs[4] = '{32'h40000001, 32'h00000002, 2'd1};  // one residue LSB
    vecs[5] = '{32'hA0000000, 32'h3243F6A9, 2'd2};
    vecs[6] = '{32'h3FFFFFFF, 32'h6487ED4F, 2'd0};
    vecs[7] = '{32'h00000001, 32'h00000002, 2'd0};
    vecs[8] = '{32'h10000000, 32'h1921FB54, 2'd0};  // pi/8, rounds down

    rst_n     = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    freq      = '0;
    phase_off = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset angle", angle, 32'h0);
    checkOutput("reset av", 32'(angle_valid), 32'd0);
    checkOutput("reset quad", 32'(quad), 32'd0);
    checkOutput("reset qv", 32'(quad_valid), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      runSingle(vecs[i], i);
    end

    // Quadrant stepping: four samples a quarter turn apart.
    exp_angle_q = '{32'h0, 32'h0, 32'h0, 32'h0};
    exp_quad_q  = '{2'd0, 2'd1, 2'd2, 2'd3};
    runStream(4, 32'h40000000, 32'h0, "step");

    // Wrap: phases 0, 0x80000001, 0x00000002.
    exp_angle_q = '{32'h0, 32'h2, 32'h3, 32'h0};
    exp_quad_q  = '{2'd0, 2'd2, 2'd0, 2'd0};
    runStream(3, 32'h80000001, 32'h0, "wrap");

    // clr and en together on edge 4. Sample 1 (phase 0 + offset) is already
    // on angle_valid at edge 3; its quad_valid and samples 2..3 are dropped.
    // Edges 5 and 6 restart from phase 0.
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 1; k <= 10 + LAT; k++) begin
      applyStimulus(k <= 6, k == 4, 32'h20000000, 32'h40000000);
      exp_av = (k == 3) || (k == 7) || (k == 8);
      exp_qv = (k == 7 + LAT) || (k == 8 + LAT);
      checkOutput($sformatf("coll av k%0d", k), 32'(angle_valid), 32'(exp_av));
      checkOutput($sformatf("coll qv k%0d", k), 32'(quad_valid), 32'(exp_qv));
      if (k == 3 || k == 7) begin
        checkOutput($sformatf("coll angle k%0d", k), angle, 32'h0);
      end
      if (k == 8) begin
        checkOutput("coll angle k8", angle, 32'h3243F6A9);
      end
      if (exp_qv) begin
        checkOutput($sformatf("coll quad k%0d", k), 32'(quad), 32'd1);
      end
    end

    // Reset in the middle of a stream with en held high.
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h01000000, 32'h0);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst angle", angle, 32'h0);
    checkOutput("midrst av", 32'(angle_valid), 32'd0);
    checkOutput("midrst quad", 32'(quad), 32'd0);
    checkOutput("midrst qv", 32'(quad_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("midrst av held", 32'(angle_valid), 32'd0);

    // After release, only the new sample may produce quad_valid, and the
    // phase restarts from 0.
    rst_n     = 1'b1;
    first_qv  = 0;
    first_av  = 0;
    qv_pulses = 0;
    av_angle  = '0;
    for (int k = 1; k <= LAT + 10; k++) begin
      applyStimulus(k == 1, 1'b0, 32'h0, 32'h20000000);
      if (angle_valid && first_av == 0) begin
        first_av = k;
        av_angle = angle;
      end
      if (quad_valid) begin
        qv_pulses++;
        if (first_qv == 0) first_qv = k;
      end
    end
    checkOutput("postrst av edge", 32'(first_av), 32'd3);
    checkOutput("postrst angle", av_angle, 32'h3243F6A9);
    checkOutput("postrst qv edge", 32'(first_qv), 32'(3 + LAT));
    checkOutput("postrst qv pulses", 32'(qv_pulses), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
